// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the 8-bit CPU control path: the bit positions of
// the 15-bit control word, the idle (INACTIVE) word, the opcode map and the
// T-state landmarks used by the microcode sequencer.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Control word layout {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}
    localparam int CP   = 14;
    localparam int EP   = 13;
    localparam int LP   = 12;
    localparam int NLMA = 11;
    localparam int NLMD = 10;
    localparam int NCE  = 9;
    localparam int NLR  = 8;
    localparam int NLI  = 7;
    localparam int NEI  = 6;
    localparam int NLA  = 5;
    localparam int EA   = 4;
    localparam int SUB  = 3;
    localparam int EU   = 2;
    localparam int NLB  = 1;
    localparam int NLO  = 0;

    localparam int CTRL_BITS = 15;

    typedef logic [CTRL_BITS-1:0] ctrl_word_t;

    // All active-low strobes high, all active-high strobes low.
    localparam ctrl_word_t INACTIVE = 15'h0FE3;

    // Opcode map; anything not listed behaves as NOP.
    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_LDA = 1;
    localparam int unsigned OP_ADD = 2;
    localparam int unsigned OP_SUB = 3;
    localparam int unsigned OP_STA = 4;
    localparam int unsigned OP_LDI = 5;
    localparam int unsigned OP_JMP = 6;
    localparam int unsigned OP_JC  = 7;
    localparam int unsigned OP_JZ  = 8;
    localparam int unsigned OP_OUT = 14;
    localparam int unsigned OP_HLT = 15;

    // Fetch occupies T0..T2; execution starts at T3.
    localparam int unsigned FETCH_LAST = 2;
    localparam int unsigned EXEC_FIRST = 3;

    // Run/halt mode of the sequencer.
    typedef enum logic {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_mode_e;

    // One-hot mask for a single control bit. Every microcode word is
    // expressed as INACTIVE with a set of these masks XORed in, so each
    // word reads as the list of strobes it asserts.
    function automatic ctrl_word_t bitm(input int idx);
        ctrl_word_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Bundles the sequencer's datapath-facing signals.
//   opcode     : IR opcode (valid from T3)
//   cf, zf     : stored ALU carry / zero flags
//   advance    : 1 = execute the current T-state and step, 0 = stall
//   ctrl       : 15-bit control word to every bus agent
//   t_state    : current T-state
//   halted     : high once HLT has executed
//   instr_done : high during the last T-state of each instruction
// Modports: master = CPU/datapath side, slave = the sequencer.
// ---------------------------------------------------------------------------
interface control_sequencer_if #(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6,
    parameter int CTRL_W   = 15
);
    localparam int TW = $clog2(T_STATES);

    logic [OPCODE_W-1:0] opcode;
    logic                cf;
    logic                zf;
    logic                advance;
    logic [CTRL_W-1:0]   ctrl;
    logic [TW-1:0]       t_state;
    logic                halted;
    logic                instr_done;

    modport master (
        output opcode, cf, zf, advance,
        input  ctrl, t_state, halted, instr_done
    );

    modport slave (
        input  opcode, cf, zf, advance,
        output ctrl, t_state, halted, instr_done
    );

endinterface

// File: rtl/control_rom.sv
// ---------------------------------------------------------------------------
// control_rom
// Purely combinational microcode table.
//   t_state : current T-state
//   opcode  : IR opcode
//   cf, zf  : ALU flags (only consulted by JC/JZ in T3)
//   word    : control word for this T-state (ungated)
//   last    : this T-state is the final one of the instruction
// ---------------------------------------------------------------------------
module control_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6
) (
    input  logic [$clog2(T_STATES)-1:0] t_state,
    input  logic [OPCODE_W-1:0]         opcode,
    input  logic                        cf,
    input  logic                        zf,
    output ctrl_word_t                  word,
    output logic                        last
);

    logic [31:0] op_ext;
    logic [31:0] ts_ext;

    // Widen both indices so opcodes wider than the defined map simply fall
    // into the default (NOP) arm.
    always_comb begin
        op_ext = 32'(opcode);
        ts_ext = 32'(t_state);
    end

    // Fetch is shared; from T3 the opcode selects the execute words.
    // Opcodes with no execute phase finish at the last fetch state.
    always_comb begin
        word = INACTIVE;
        last = 1'b0;
        if (ts_ext <= FETCH_LAST) begin
            case (ts_ext)
                0:       word = INACTIVE ^ (bitm(EP) | bitm(NLMA));
                1:       word = INACTIVE ^ bitm(CP);
                default: word = INACTIVE ^ (bitm(NCE) | bitm(NLI));
            endcase
            if (ts_ext == FETCH_LAST) begin
                case (op_ext)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                    OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last = 1'b0;
                    default:                              last = 1'b1;
                endcase
            end
        end else begin
            case (op_ext)
                OP_LDA: begin
                    case (ts_ext)
                        3: word = INACTIVE ^ (bitm(NEI) | bitm(NLMA));
                        4: begin
                            word = INACTIVE ^ (bitm(NCE) | bitm(NLA));
                            last = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADD, OP_SUB: begin
                    case (ts_ext)
                        3: word = INACTIVE ^ (bitm(NEI) | bitm(NLMA));
                        4: word = INACTIVE ^ (bitm(NCE) | bitm(NLB));
                        5: begin
                            word = INACTIVE ^ (bitm(EU) | bitm(NLA));
                            if (op_ext == OP_SUB) begin
                                word = word ^ bitm(SUB);
                            end
                            last = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_STA: begin
                    case (ts_ext)
                        3: word = INACTIVE ^ (bitm(NEI) | bitm(NLMA));
                        4: word = INACTIVE ^ (bitm(EA) | bitm(NLMD));
                        5: begin
                            word = INACTIVE ^ bitm(NLR);
                            last = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_LDI: begin
                    if (ts_ext == EXEC_FIRST) begin
                        word = INACTIVE ^ (bitm(NEI) | bitm(NLA));
                        last = 1'b1;
                    end
                end
                OP_JMP, OP_JC, OP_JZ: begin
                    // A conditional jump not taken still ends at T3, just
                    // without loading the program counter.
                    if (ts_ext == EXEC_FIRST) begin
                        if ((op_ext == OP_JMP) ||
                            (op_ext == OP_JC && cf) ||
                            (op_ext == OP_JZ && zf)) begin
                            word = INACTIVE ^ (bitm(NEI) | bitm(LP));
                        end
                        last = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (ts_ext == EXEC_FIRST) begin
                        word = INACTIVE ^ (bitm(EA) | bitm(NLO));
                        last = 1'b1;
                    end
                end
                OP_HLT: begin
                    // Idle word; the sequencer latches the halt at this edge.
                    if (ts_ext == EXEC_FIRST) begin
                        last = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Microcode sequencer for the 8-bit CPU. Owns the T-state counter and the
// halt flag, looks up the control word in control_rom and gates it with
// reset, stall and halt.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : control_sequencer_if.slave (opcode, cf, zf, advance in;
//         ctrl, t_state, halted, instr_done out)
// CTRL_W must be 15; the bit map is fixed by cpu_ctrl_pkg.
// ---------------------------------------------------------------------------
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_STATES = 6,
    parameter int CTRL_W   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.slave   bus
);

    localparam int TW = $clog2(T_STATES);

    logic [TW-1:0] t_q;
    logic [TW-1:0] t_d;
    seq_mode_e     mode_q;
    seq_mode_e     mode_d;
    ctrl_word_t    rom_word;
    logic          rom_last;
    logic          step;
    logic          gate;

    control_rom #(
        .OPCODE_W (OPCODE_W),
        .T_STATES (T_STATES)
    ) u_rom (
        .t_state (t_q),
        .opcode  (bus.opcode),
        .cf      (bus.cf),
        .zf      (bus.zf),
        .word    (rom_word),
        .last    (rom_last)
    );

    // State register: T-state counter and run/halt mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q    <= '0;
            mode_q <= SEQ_RUN;
        end else begin
            t_q    <= t_d;
            mode_q <= mode_d;
        end
    end

    // Next state. A stall or halt freezes the counter so no strobe is ever
    // repeated. The wrap at T_STATES-1 only guards against a missing 'last'.
    always_comb begin
        t_d    = t_q;
        mode_d = mode_q;
        step   = bus.advance && (mode_q == SEQ_RUN);
        if (step) begin
            if (rom_last || (t_q == TW'(T_STATES - 1))) begin
                t_d = '0;
            end else begin
                t_d = t_q + 1'b1;
            end
            if ((32'(bus.opcode) == OP_HLT) && (32'(t_q) == EXEC_FIRST)) begin
                mode_d = SEQ_HALT;
            end
        end
    end

    // Outputs. Reset, stall and halt all force the idle word and suppress
    // instr_done, so bus agents only ever see strobes on a real step.
    always_comb begin
        gate           = rst || !bus.advance || (mode_q == SEQ_HALT);
        bus.ctrl       = gate ? CTRL_W'(INACTIVE) : CTRL_W'(rom_word);
        bus.instr_done = !gate && rom_last;
        bus.t_state    = t_q;
        bus.halted     = (mode_q == SEQ_HALT);
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer. A reference model holds each
// instruction as a list of control words (fetch + execute) and walks it one
// step per advancing cycle; directed sequences are followed by random
// traffic.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    localparam int OPW = 4;
    localparam int TS  = 6;
    localparam int CW  = 15;

    localparam logic [14:0] W_IDLE = 15'h0FE3;
    localparam logic [14:0] W_JMP  = 15'h1FA3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_sequencer_if #(.OPCODE_W(OPW), .T_STATES(TS), .CTRL_W(CW)) bus ();

    control_sequencer #(
        .OPCODE_W (OPW),
        .T_STATES (TS),
        .CTRL_W   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int          m_idx;
    bit          m_halted;
    int          m_op;
    int          next_op;
    logic [14:0] m_prog[$];
    string       phase;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    // Word list of one whole instruction. JC/JZ store the not-taken word at
    // T3; the actual word is resolved from the live flags when that step is
    // checked.
    function automatic void loadInstr(input int op);
        m_op   = op;
        m_prog = '{15'h27E3, 15'h4FE3, 15'h0D63};
        case (op)
            1:  begin m_prog.push_back(15'h07A3); m_prog.push_back(15'h0DC3); end
            2:  begin m_prog.push_back(15'h07A3); m_prog.push_back(15'h0DE1);
                      m_prog.push_back(15'h0FC7); end
            3:  begin m_prog.push_back(15'h07A3); m_prog.push_back(15'h0DE1);
                      m_prog.push_back(15'h0FCF); end
            4:  begin m_prog.push_back(15'h07A3); m_prog.push_back(15'h0BF3);
                      m_prog.push_back(15'h0EE3); end
            5:  m_prog.push_back(15'h0F83);
            6:  m_prog.push_back(W_JMP);
            7, 8, 15: m_prog.push_back(W_IDLE);
            14: m_prog.push_back(15'h0FF2);
            default: ;
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare outputs
    // just after, then advance the model to mirror the coming rising edge.
    task automatic applyStimulus(input bit r, input bit adv, input bit c,
                                 input bit z, input bit do_check);
        logic [14:0] exp_word;
        bit          gated;
        bit          exp_done;
        @(negedge clk);
        rst         = r;
        bus.advance = adv;
        bus.opcode  = OPW'(m_op);
        bus.cf      = c;
        bus.zf      = z;
        #1;
        gated    = r || !adv || m_halted;
        exp_word = gated ? W_IDLE : m_prog[m_idx];
        if (!gated && m_idx == 3 && m_op == 7) exp_word = c ? W_JMP : W_IDLE;
        if (!gated && m_idx == 3 && m_op == 8) exp_word = z ? W_JMP : W_IDLE;
        exp_done = !gated && (m_idx == m_prog.size() - 1);
        if (do_check) begin
            checkOutput("ctrl",       32'(bus.ctrl),       32'(exp_word));
            checkOutput("t_state",    32'(bus.t_state),    32'(m_idx));
            checkOutput("halted",     32'(bus.halted),     32'(m_halted));
            checkOutput("instr_done", 32'(bus.instr_done), 32'(exp_done));
        end
        if (r) begin
            m_idx    = 0;
            m_halted = 1'b0;
            loadInstr(next_op);
        end else if (!m_halted && adv) begin
            if (m_idx == m_prog.size() - 1) begin
                if (m_op == 15) m_halted = 1'b1;
                m_idx = 0;
                loadInstr(next_op);
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic runInstr(input string name, input int follow_op,
                            input int cycles, input bit c, input bit z);
        phase   = name;
        next_op = follow_op;
        repeat (cycles) applyStimulus(1'b0, 1'b1, c, z, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.advance = 1'b0;
        bus.opcode  = '0;
        bus.cf      = 1'b0;
        bus.zf      = 1'b0;
        m_idx       = 0;
        m_halted    = 1'b0;
        next_op     = 1;
        phase       = "reset";
        loadInstr(1);

        // First edge establishes a known state; check from the second.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        runInstr("lda",    2, 5, 1'b0, 1'b0);
        runInstr("add",    3, 6, 1'b0, 1'b0);
        runInstr("sub",    7, 6, 1'b0, 1'b0);
        runInstr("jc_t",   7, 4, 1'b1, 1'b0);
        runInstr("jc_nt",  8, 4, 1'b0, 1'b1);
        runInstr("jz_t",   8, 4, 1'b0, 1'b1);
        runInstr("jz_nt",  1, 4, 1'b1, 1'b0);

        // Stall three cycles in T1 of an LDA.
        phase   = "stall";
        next_op = 11;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        runInstr("nop11",  4, 3, 1'b0, 1'b0);

        // Reset in T4 of STA aborts it.
        phase   = "sta_rst";
        next_op = 15;
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // HLT, then idle with arbitrary advance, then release by reset.
        phase   = "hlt";
        next_op = 5;
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        runInstr("ldi",    6, 4, 1'b0, 1'b0);
        runInstr("jmp",   14, 4, 1'b0, 1'b0);
        runInstr("out",    0, 4, 1'b0, 1'b0);

        // Random traffic: flags toggle every cycle, HLT is made rarer and
        // reset is likelier while halted so the run keeps moving.
        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            bit r;
            next_op = int'($urandom_range(0, 15));
            if (next_op == 15 && ($urandom % 3) != 0) next_op = 0;
            r = m_halted ? (($urandom % 6) == 0) : (($urandom % 100) == 0);
            applyStimulus(r, ($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised microcode sequencer that generates the 15-bit CPU control word from the IR opcode, the T-state counter and the ALU flags. It is the next generation of the fixed 6-step controller and sits between the instruction register/ALU and every bus agent in the 8-bit CPU. Over the fixed controller it adds:
- variable-length instructions (early return to fetch)
- conditional jumps on CF/ZF
- HLT
- a stall/single-step handshake

Parameters:
OPCODE_W, 4, opcode width; opcodes outside the defined set decode as NOP.
T_STATES, 6, T-state counter modulus; minimum 6, since STA and ADD/SUB need T0..T5.
CTRL_W, 15, control word width; the bit map is fixed by cpu_ctrl_pkg and CTRL_W must equal 15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  OPCODE_W  opcode from the instruction register; valid from T3
cf  in  1  stored ALU carry flag
zf  in  1  stored ALU zero flag
advance  in  1  1 = execute the current T-state and step; 0 = stall
ctrl  out  CTRL_W  control word {Cp,Ep,Lp,nLma,nLmd,nCE,nLr,nLi,nEi,nLa,Ea,sub,Eu,nLb,nLo}, bit 14 first
t_state  out  $clog2(T_STATES)  current T-state
halted  out  1  high once HLT has executed
instr_done  out  1  high during the last T-state of each instruction

Behaviour:
- Word constants:
  - INACTIVE = 15'h0FE3: all active-low bits high, all active-high bits low.
  - All listed words are INACTIVE with only the named bits toggled.
- Reset (rst=1 at a clk edge): t_state=0, halted=0.
  - While rst=1: ctrl=INACTIVE and instr_done=0, combinationally.
  - Reset mid-instruction aborts the instruction; the first post-reset cycle is T0.
- Decode is combinational from (t_state, opcode, cf, zf).
- ctrl is forced to INACTIVE when rst=1, advance=0 or halted=1.
- A stall holds t_state, so Cp and other strobes are never repeated.
- Step rule at a clk edge with advance=1 and not halted:
  - If instr_done, t_state goes to 0.
  - Otherwise t_state increments; wrap at T_STATES-1 is a safety fallback only.
- Fetch, common to all instructions:
  - T0: Ep, nLma=0 → 0x27E3
  - T1: Cp → 0x4FE3
  - T2: nCE=0, nLi=0 → 0x0D63
- Execute (T3 onward) per opcode:
  - 0 NOP: instr_done at T2.
  - 1 LDA: T3 nEi,nLma; T4 nCE,nLa (done).
  - 2 ADD: T3 nEi,nLma; T4 nCE,nLb; T5 Eu,nLa → 0x0FC7 (done).
  - 3 SUB: as ADD, T5 with sub=1 → 0x0FCF.
  - 4 STA: T3 nEi,nLma; T4 Ea,nLmd; T5 nLr (done).
  - 5 LDI: T3 nEi,nLa (done).
  - 6 JMP: T3 nEi,Lp → 0x1FA3 (done).
  - 7 JC: T3 is the JMP word if cf=1, else INACTIVE; done either way.
  - 8 JZ: as JC, using zf.
  - 14 OUT: T3 Ea,nLo → 0x0FF2 (done).
  - 15 HLT: T3 word is INACTIVE; at the T3 edge (advance=1), halted←1 and t_state←0. Exit only via rst.
  - 9..13: NOP.
- cf/zf are sampled combinationally during T3 only; flag changes at other T-states have no effect.
- instr_done is 0 while stalled or halted.

Decomposition:
- cpu_ctrl_pkg:
  - control bit index constants (CP=14 … NLO=0)
  - INACTIVE word
  - opcode localparams (OP_NOP … OP_HLT)
  - FETCH_LAST=2
- Sub-module control_rom: purely combinational (t_state, opcode, cf, zf) → {word, last}.
- control_sequencer owns the counter, the halt flag, the stall/rst gating and the outputs.

Test Plan:
- Reset + fetch: rst=1 for 2 cycles, then advance=1, opcode=1 (LDA) → ctrl 0x27E3, 0x4FE3, 0x0D63, then LDA words; instr_done at T4; next cycle t_state=0.
- ADD vs SUB: opcode=2 → T5 ctrl=0x0FC7; opcode=3 → T5 ctrl=0x0FCF; next cycle t_state=0 in both cases.
- Conditional jumps: JC with cf=1 → T3 0x1FA3; JC with cf=0 → T3 0x0FE3; JZ with zf=1/0 gives the same pair. All return to T0 after T3.
- Stall: advance=0 for 3 cycles during T1 → ctrl=0x0FE3, t_state stays 1. Re-asserting advance gives exactly one 0x4FE3 cycle.
- HLT: opcode=15 → halted=1 after T3, ctrl=0x0FE3 indefinitely for any advance value. rst=1 → halted=0, t_state=0.
- Reset mid-STA at T4 → next cycle t_state=0, ctrl=0x0FE3 while rst=1. Undefined opcode 11 completes as NOP (instr_done at T2).
